qpsk_framer: RTL

QPSK_FRAMER -- requirements
Module: qpsk_framer

---
 rtl/qpsk_pkg.sv | 26 ++
 rtl/qpsk_framer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/qpsk_pkg.sv
// qpsk_pkg -- shared QPSK framing definitions.
// Holds the framer state type, the 2-bit signed symbol codes and the default
// frame geometry so downstream blocks (rotator, deframer) agree on encoding.
package qpsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Signed 2-bit symbol codes: +1, -1 and idle/zero.
    localparam logic [1:0] SYM_P1 = 2'b01;
    localparam logic [1:0] SYM_M1 = 2'b11;
    localparam logic [1:0] SYM_Z  = 2'b00;

    localparam int PRE_LEN_DEF = 8;
    localparam int PAY_LEN_DEF = 64;

    // Bit 0 -> +1, bit 1 -> -1.
    function automatic logic [1:0] map_bit(input logic b);
        return b ? SYM_M1 : SYM_P1;
    endfunction

endpackage

// File: rtl/qpsk_framer.sv
// qpsk_framer -- builds a QPSK frame: PRE_LEN alternating preamble symbols
// followed by PAY_LEN payload symbols made from pairs of serial bits.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   frame-start request (honoured only in IDLE)
//   bit_in     in   serial payload bit
//   bit_valid  in   bit_in valid this cycle
//   bit_ready  out  payload bit accepted this cycle (state == PAY)
//   I, Q       out  2-bit signed symbols (+1=01, -1=11, idle=00)
//   sym_en     out  I/Q carry a new symbol this cycle
//   frame_done out  one-cycle pulse on the final payload symbol
module qpsk_framer
    import qpsk_pkg::*;
#(
    parameter int PRE_LEN = PRE_LEN_DEF,
    parameter int PAY_LEN = PAY_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [1:0] I,
    output logic [1:0] Q,
    output logic       sym_en,
    output logic       frame_done
);

    localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
    localparam logic [9:0] PAY_LAST = 10'(PAY_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] i_q, i_d, q_q, q_d;
    logic       sym_en_q, sym_en_d;
    logic [7:0] pre_cnt_q, pre_cnt_d;
    logic [9:0] pay_cnt_q, pay_cnt_d;
    logic       half_q, half_d;     // first bit of a pair is waiting
    logic       first_q, first_d;   // that first bit (becomes I)
    logic       accept;

    assign bit_ready  = (state_q == PAY);
    assign accept     = bit_valid && bit_ready;
    assign I          = i_q;
    assign Q          = q_q;
    assign sym_en     = sym_en_q;
    assign frame_done = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        q_d       = q_q;
        sym_en_d  = 1'b0;
        pre_cnt_d = pre_cnt_q;
        pay_cnt_d = pay_cnt_q;
        half_d    = half_q;
        first_d   = first_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d       = SYM_P1;
                    q_d       = SYM_P1;
                    sym_en_d  = 1'b1;
                    pre_cnt_d = 8'd1;
                    pay_cnt_d = 10'd0;
                    half_d    = 1'b0;
                    state_d   = (PRE_LEN == 1) ? PAY : PRE;
                end
            end
            PRE: begin
                // pre_cnt holds the index of the symbol being loaded now.
                i_d       = pre_cnt_q[0] ? SYM_M1 : SYM_P1;
                q_d       = pre_cnt_q[0] ? SYM_M1 : SYM_P1;
                sym_en_d  = 1'b1;
                pre_cnt_d = pre_cnt_q + 8'd1;
                if (pre_cnt_q == PRE_LAST)
                    state_d = PAY;
            end
            PAY: begin
                if (accept) begin
                    if (!half_q) begin
                        first_d = bit_in;
                        half_d  = 1'b1;
                    end else begin
                        i_d       = map_bit(first_q);
                        q_d       = map_bit(bit_in);
                        sym_en_d  = 1'b1;
                        half_d    = 1'b0;
                        pay_cnt_d = pay_cnt_q + 10'd1;
                        if (pay_cnt_q == PAY_LAST)
                            state_d = DONE;
                    end
                end
            end
            DONE: begin
                // The last symbol is shown during DONE; clear on the way out.
                i_d     = SYM_Z;
                q_d     = SYM_Z;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= SYM_Z;
            q_q       <= SYM_Z;
            sym_en_q  <= 1'b0;
            pre_cnt_q <= 8'd0;
            pay_cnt_q <= 10'd0;
            half_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            q_q       <= q_d;
            sym_en_q  <= sym_en_d;
            pre_cnt_q <= pre_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            half_q    <= half_d;
            first_q   <= first_d;
        end
    end

endmodule
